// File: rtl/order_encode_stream.sv
// Order encoder: buffers buy/sell/cancel requests in a small FIFO, assigns
// sequential tokens to new orders and serialises each request as a 16-byte
// message over an AXI-Stream master, MSB first.
module order_encode_stream #(
  parameter int          DATA_W     = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] STOCK_ID   = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [31:0]       in_px,
  input  logic [31:0]       in_qty,
  input  logic [31:0]       in_token,
  output logic              tok_valid,
  output logic [31:0]       tok_id,
  output logic              err_drop,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [31:0]       msg_count
);

  localparam int NB = 128 / DATA_W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] token;
    logic [31:0] qty;
    logic [31:0] px;
  } req_t;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t        state, state_next;
  req_t          mem [FIFO_DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [31:0]   tok_ctr;
  logic [127:0]  sr, head_msg;
  logic [BW-1:0] beat;
  logic          accept, push, is_new, drop, pop, fifo_empty, last_hs;

  assign accept     = in_valid & in_ready;
  assign push       = accept & (in_op != 2'd3);
  assign is_new     = accept & ~in_op[1];
  assign drop       = accept & (in_op == 2'd3);
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  assign m_axis_tvalid = (state == S_SEND);
  assign m_axis_tlast  = m_axis_tvalid & (beat == LAST_BEAT);
  assign m_axis_tdata  = sr[127 -: DATA_W];
  assign last_hs       = m_axis_tvalid & m_axis_tready & (beat == LAST_BEAT);

  // Occupancy after this cycle's push and pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // Request storage; new orders carry the issued token, cancels the target token.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; occupancy/pointers alone decide what is valid.
    if (push) mem[wr_ptr] <= '{op: in_op, token: (in_op[1] ? in_token : tok_ctr), qty: in_qty, px: in_px};
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      in_ready <= (count_next != FULL_CNT);
    end
  end

  // Token issue, token pulse and illegal-op drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_ctr   <= 32'd1;
      tok_valid <= 1'b0;
      tok_id    <= '0;
      err_drop  <= 1'b0;
    end else begin
      tok_valid <= is_new;
      err_drop  <= drop;
      if (is_new) begin
        tok_id  <= tok_ctr;
        tok_ctr <= (tok_ctr == 32'hFFFF_FFFF) ? 32'd1 : tok_ctr + 32'd1;
      end
    end
  end

  // Format the head entry as the 128-bit wire message.
  always_comb begin
    head_msg = '0;
    unique case (head.op)
      2'd0:    head_msg = {8'h4F, 8'h42, head.token, head.qty, head.px, STOCK_ID};
      2'd1:    head_msg = {8'h4F, 8'h53, head.token, head.qty, head.px, STOCK_ID};
      default: head_msg = {8'h58, 8'h00, head.token, head.qty, 32'd0, STOCK_ID};
    endcase
  end

  // Tx FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Tx FSM: pop when idle, or on the last beat to chain messages without a bubble.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        state_next = S_SEND;
      end
      S_SEND: if (last_hs) begin
        if (!fifo_empty) pop = 1'b1;
        else             state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Message shift register, beat index and completed-message counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      beat      <= '0;
      msg_count <= '0;
    end else begin
      if (pop) begin
        sr   <= head_msg;
        beat <= '0;
      end else if (m_axis_tvalid && m_axis_tready && beat != LAST_BEAT) begin
        sr   <= sr << DATA_W;
        beat <= beat + 1'b1;
      end
      if (last_hs) msg_count <= msg_count + 32'd1;
    end
  end

endmodule
